// File: rtl/sha3_scan_pkg.sv
// Shared types for the SHA3 result scanner: lane/nonce/hash payloads and the scan state.
package sha3_scan_pkg;
  localparam int unsigned LANE_W             = 64;
  localparam int unsigned NONCE_W            = 32;
  localparam int unsigned NUM_LANES          = 25;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

  typedef logic [LANE_W-1:0]                 lane_t;
  typedef logic [NONCE_W-1:0]                nonce_t;
  typedef logic [NUM_LANES-1:0][LANE_W-1:0]  hash_t;
  typedef logic [4:0][LANE_W-1:0]            row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/sha3_nonce_fifo.sv
// In-order nonce tracking FIFO; a push is accepted while full if a pop happens in the same cycle.
module sha3_nonce_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/sha3_result_evaluator.sv
// Matches in-order hasher results to dispatched nonces and latches the first hash below threshold.
module sha3_result_evaluator
  import sha3_scan_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned TEST_LANE  = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  lane_t       threshold,
  input  logic        dispatch,
  input  nonce_t      dispatch_nonce,
  input  logic        hashgood,
  input  row_t        hasha,
  input  row_t        hashb,
  input  row_t        hashc,
  input  row_t        hashd,
  input  row_t        hashe,
  output logic        oready,
  output logic        otake,
  output logic        oevaluating,
  output logic        ofound,
  output hash_t       ohash,
  output nonce_t      ononce,
  output logic [31:0] ocount,
  output logic        oerror
);
  localparam logic [4:0] LANE_IDX = 5'(TEST_LANE);

  state_e state_q;
  lane_t  thr_q;
  logic   s1_valid_q;
  hash_t  s1_hash_q;
  nonce_t s1_nonce_q;

  logic   fifo_full, fifo_empty;
  nonce_t fifo_rdata;
  logic   active_c, start_acc_c, pop_c, push_c, hit_c, err_c;
  hash_t  hash_c;

  assign hash_c      = {hashe, hashd, hashc, hashb, hasha};
  assign active_c    = (state_q != ST_IDLE);
  assign oready      = (state_q != ST_ARMED) && fifo_empty && !s1_valid_q;
  assign otake       = !fifo_full;
  assign oevaluating = active_c && (!fifo_empty || s1_valid_q);
  assign start_acc_c = start && oready;
  assign pop_c       = active_c && hashgood && !fifo_empty;
  assign push_c      = active_c && dispatch;
  assign hit_c       = s1_valid_q && (s1_hash_q[LANE_IDX] < thr_q);
  // Stray result (idle or nothing outstanding) or a dispatch the full FIFO cannot absorb.
  assign err_c       = (hashgood && !pop_c) || (push_c && fifo_full && !pop_c);

  sha3_nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (dispatch_nonce),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      thr_q      <= '1;
      s1_valid_q <= 1'b0;
      s1_hash_q  <= '0;
      s1_nonce_q <= '0;
      ofound     <= 1'b0;
      oerror     <= 1'b0;
      ocount     <= '0;
      ohash      <= '0;
      ononce     <= '0;
    end else begin
      s1_valid_q <= pop_c;
      if (pop_c) begin
        s1_hash_q  <= hash_c;
        s1_nonce_q <= fifo_rdata;
      end
      if (start_acc_c) begin
        state_q <= ST_ARMED;
        thr_q   <= threshold;
        ofound  <= 1'b0;
        ocount  <= '0;
        oerror  <= 1'b0;
      end else begin
        if (s1_valid_q) ocount <= ocount + 32'd1;
        // Only the first hit of a scan is kept; later hits are just counted.
        if (hit_c && state_q == ST_ARMED) begin
          state_q <= ST_DONE;
          ofound  <= 1'b1;
          ohash   <= s1_hash_q;
          ononce  <= s1_nonce_q;
        end
      end
      if (err_c) oerror <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sha3_result_evaluator.sv
// Directed and random stimulus checked every cycle against a queue-based scan model.
module tb_sha3_result_evaluator;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [1599:0] h;
    logic [31:0]   n;
  } res_t;

  logic              clk = 1'b0;
  logic              rstn, start, dispatch, hashgood;
  logic [63:0]       threshold;
  logic [31:0]       dispatch_nonce;
  logic [4:0][63:0]  ha, hb, hc, hd, he;
  logic              oready, otake, oevaluating, ofound, oerror;
  logic [24:0][63:0] ohash;
  logic [31:0]       ononce, ocount;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: 0 idle, 1 armed, 2 done.
  int            m_st;
  logic [31:0]   m_q[$];
  res_t          m_pend[$];
  logic [63:0]   m_thr;
  logic          m_found, m_err;
  logic [31:0]   m_cnt, m_nonce;
  logic [1599:0] m_hash;

  sha3_result_evaluator dut (
    .clk(clk), .rstn(rstn), .start(start), .threshold(threshold),
    .dispatch(dispatch), .dispatch_nonce(dispatch_nonce), .hashgood(hashgood),
    .hasha(ha), .hashb(hb), .hashc(hc), .hashd(hd), .hashe(he),
    .oready(oready), .otake(otake), .oevaluating(oevaluating), .ofound(ofound),
    .ohash(ohash), .ononce(ononce), .ocount(ocount), .oerror(oerror)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_q.delete(); m_pend.delete();
    m_thr = '1; m_found = 0; m_err = 0; m_cnt = 0; m_nonce = 0; m_hash = '0;
  endtask

  task automatic model_edge();
    bit   ready, active;
    res_t ev[$];
    res_t r;
    ready  = (m_st != 1) && (m_q.size() == 0) && (m_pend.size() == 0);
    active = (m_st != 0);
    ev = m_pend;
    m_pend.delete();
    if (start && ready) begin
      m_st = 1; m_thr = threshold; m_found = 0; m_cnt = 0; m_err = 0;
    end else begin
      foreach (ev[i]) begin
        m_cnt = m_cnt + 32'd1;
        if (ev[i].h[63:0] < m_thr && m_st == 1) begin
          m_st = 2; m_found = 1; m_hash = ev[i].h; m_nonce = ev[i].n;
        end
      end
    end
    if (hashgood) begin
      if (active && m_q.size() > 0) begin
        r.h = {he, hd, hc, hb, ha};
        r.n = m_q.pop_front();
        m_pend.push_back(r);
      end else m_err = 1;
    end
    if (active && dispatch) begin
      if (m_q.size() < DEPTH) m_q.push_back(dispatch_nonce);
      else m_err = 1;
    end
  endtask

  task automatic compare_all();
    check("oready", 64'(oready), 64'((m_st != 1) && m_q.size() == 0 && m_pend.size() == 0));
    check("otake", 64'(otake), 64'(m_q.size() < DEPTH));
    check("oevaluating", 64'(oevaluating), 64'((m_st != 0) && (m_q.size() > 0 || m_pend.size() > 0)));
    check("ofound", 64'(ofound), 64'(m_found));
    check("ocount", 64'(ocount), 64'(m_cnt));
    check("oerror", 64'(oerror), 64'(m_err));
    check("ononce", 64'(ononce), 64'(m_nonce));
    check("ohash_lane0", ohash[0], m_hash[63:0]);
    check("ohash_all", 64'(ohash == m_hash), 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    start = 0; dispatch = 0; hashgood = 0;
    compare_all();
  endtask

  task automatic set_hash(input logic [63:0] l0);
    for (int i = 0; i < 5; i++) begin
      ha[i] = {$urandom, $urandom}; hb[i] = {$urandom, $urandom}; hc[i] = {$urandom, $urandom};
      hd[i] = {$urandom, $urandom}; he[i] = {$urandom, $urandom};
    end
    ha[0] = l0;
  endtask

  task automatic do_start(input logic [63:0] thr);
    start = 1; threshold = thr; step();
  endtask

  task automatic do_dispatch(input logic [31:0] n);
    dispatch = 1; dispatch_nonce = n; step();
  endtask

  task automatic do_hash(input logic [63:0] l0);
    hashgood = 1; set_hash(l0); step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge, released on a falling edge.
  task automatic do_reset();
    #2 rstn = 0;
    #1;
    model_reset();
    check("rst_ofound", 64'(ofound), 64'd0);
    check("rst_oerror", 64'(oerror), 64'd0);
    check("rst_ocount", 64'(ocount), 64'd0);
    check("rst_ononce", 64'(ononce), 64'd0);
    check("rst_ohash_zero", 64'(ohash == '0), 64'd1);
    check("rst_oready", 64'(oready), 64'd1);
    check("rst_otake", 64'(otake), 64'd1);
    check("rst_oeval", 64'(oevaluating), 64'd0);
    @(negedge clk);
    rstn = 1;
    step();
  endtask

  initial begin
    logic [63:0] lv;
    rstn = 0; start = 0; dispatch = 0; hashgood = 0;
    threshold = '0; dispatch_nonce = '0;
    set_hash('1);
    model_reset();
    #2;
    check("init_oready", 64'(oready), 64'd1);
    check("init_ocount", 64'(ocount), 64'd0);
    @(negedge clk);
    rstn = 1;
    step();

    // Single hit among six results.
    do_start(64'h0000_0100_0000_0000);
    for (int i = 0; i < 6; i++) do_dispatch(32'(i));
    for (int i = 0; i < 6; i++) begin
      do_hash(i == 3 ? 64'h10 : '1);
      if (i == 3) check("hit_lat1", 64'(ofound), 64'd0);
      if (i == 4) check("hit_lat2", 64'(ofound), 64'd1);
    end
    idle(2);
    check("s40_nonce", 64'(ononce), 64'd3);
    check("s40_count", 64'(ocount), 64'd6);
    check("s40_err", 64'(oerror), 64'd0);

    // Two hits: only the first is kept.
    do_start(64'h0000_0100_0000_0000);
    do_dispatch(1); do_dispatch(2);
    do_hash(64'd5); do_hash(64'd1);
    idle(2);
    check("s41_nonce", 64'(ononce), 64'd1);
    check("s41_count", 64'(ocount), 64'd2);

    // Overflow dispatch, then a dispatch into a full FIFO alongside a pop.
    do_start(64'h0000_0100_0000_0000);
    for (int i = 0; i < 8; i++) do_dispatch(32'(10 + i));
    check("s42_take_full", 64'(otake), 64'd0);
    do_dispatch(32'd99);
    check("s42_err", 64'(oerror), 64'd1);
    for (int i = 0; i < 8; i++) do_hash(i == 7 ? 64'd0 : '1);
    idle(2);
    do_start(64'h0000_0100_0000_0000);
    for (int i = 0; i < 8; i++) do_dispatch(32'(20 + i));
    dispatch = 1; dispatch_nonce = 32'd28; hashgood = 1; set_hash('1); step();
    check("s42_noerr", 64'(oerror), 64'd0);
    check("s42_take_still_full", 64'(otake), 64'd0);
    for (int i = 0; i < 8; i++) do_hash(i == 7 ? 64'd0 : '1);
    idle(2);

    // Stray result, then a start that arrives while busy.
    do_start(64'h100);
    do_hash(64'd0);
    check("s43_err", 64'(oerror), 64'd1);
    check("s43_count", 64'(ocount), 64'd0);
    do_dispatch(32'h77);
    check("s43_eval", 64'(oevaluating), 64'd1);
    do_start(64'd0);
    do_hash(64'd5);
    idle(2);
    check("s43_thr_kept", 64'(ofound), 64'd1);
    check("s43_nonce", 64'(ononce), 64'h77);

    // Reset mid-scan with four nonces queued.
    do_start(64'h100);
    for (int i = 0; i < 4; i++) do_dispatch(32'(40 + i));
    do_reset();
    do_start(64'd1);
    do_dispatch(32'd9);
    do_hash(64'd0);
    idle(2);
    check("s44_found", 64'(ofound), 64'd1);
    check("s44_nonce", 64'(ononce), 64'd9);

    // Equality is not a hit; threshold zero never hits.
    do_reset();
    do_start(64'h1234);
    do_dispatch(1); do_dispatch(2);
    do_hash(64'h1234);
    idle(2);
    check("s45_eq_nohit", 64'(ofound), 64'd0);
    do_hash(64'h1233);
    idle(2);
    check("s45_below_hit", 64'(ofound), 64'd1);
    do_reset();
    do_start(64'd0);
    for (int i = 0; i < 3; i++) do_dispatch(32'(i));
    for (int i = 0; i < 3; i++) do_hash(64'd0);
    idle(2);
    check("s45_zero_nohit", 64'(ofound), 64'd0);
    check("s45_zero_count", 64'(ocount), 64'd3);
    do_reset();

    // Random traffic, including stray results, overflows, ignored starts and resets.
    for (int c = 0; c < 1500; c++) begin
      if (c % 500 == 499) do_reset();
      if ($urandom_range(0, 9) == 0) begin
        start = 1;
        threshold = {$urandom, $urandom};
      end
      dispatch = ($urandom_range(0, 9) < 6);
      dispatch_nonce = $urandom;
      hashgood = ($urandom_range(0, 9) < 5);
      case ($urandom_range(0, 4))
        0:       lv = {$urandom, $urandom};
        1:       lv = m_thr;
        2:       lv = m_thr - 64'd1;
        3:       lv = m_thr + 64'd1;
        default: lv = 64'd0;
      endcase
      set_hash(lv);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
